// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
//
// On a start request in IDLE, it latches a PAT_W-bit pattern, a repeat count and an inter-pass
// gap. It then shifts the pattern out MSB first, once per pass. Idle gap cycles separate
// consecutive passes. A one-cycle DONE state follows the last bit. Data outputs are registered,
// so the first bit appears in the cycle after the start edge.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset, dominates everything
//   start_i    transfer request, sampled only while ready_o=1
//   pattern_i  bit pattern, sent MSB first
//   reps_i     number of passes (0 is treated as 1)
//   gap_i      idle cycles between consecutive passes
//   ready_o    high only in IDLE
//   x_out_o    serial data bit (registered)
//   x_valid_o  x_out_o carries a pattern bit (registered)
//   busy_o     high in SHIFT and GAP
//   done_o     one-cycle pulse in DONE
//   cst_o      current state code, for debug

module seq_pattern_tx #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [CNT_W-1:0] reps_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             ready_o,
    output logic             x_out_o,
    output logic             x_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       cst_o
);

    localparam int unsigned IdxW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IdxW-1:0] IdxMax = IdxW'(PAT_W - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StShift = 3'b001,
        StGap   = 3'b010,
        StDone  = 3'b011
    } state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    // Passes still to send after the current one. Holding reps-1 instead of reps means the
    // maximum count fits in CNT_W bits and the counter never wraps.
    logic [CNT_W-1:0] pass_left_q, pass_left_d;
    logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    // Index of the bit currently presented on x_out_o.
    logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
    logic             x_out_q, x_out_d;
    logic             x_valid_q, x_valid_d;

    logic [IdxW-1:0]  idx_dec;
    assign idx_dec = bit_idx_q - IdxW'(1);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pat_q       <= '0;
            pass_left_q <= '0;
            gap_lat_q   <= '0;
            gap_cnt_q   <= '0;
            bit_idx_q   <= '0;
            x_out_q     <= 1'b0;
            x_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            pass_left_q <= pass_left_d;
            gap_lat_q   <= gap_lat_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_idx_q   <= bit_idx_d;
            x_out_q     <= x_out_d;
            x_valid_q   <= x_valid_d;
        end
    end

    // Next-state logic. x_out_d/x_valid_d describe the bit shown in the cycle after this edge,
    // which keeps the serial outputs registered while still giving latency 1 from start.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        pass_left_d = pass_left_q;
        gap_lat_d   = gap_lat_q;
        gap_cnt_d   = gap_cnt_q;
        bit_idx_d   = bit_idx_q;
        x_out_d     = 1'b0;
        x_valid_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StShift;
                    pat_d       = pattern_i;
                    pass_left_d = (reps_i == '0) ? '0 : reps_i - CNT_W'(1);
                    gap_lat_d   = gap_i;
                    gap_cnt_d   = '0;
                    bit_idx_d   = IdxMax;
                    x_out_d     = pattern_i[PAT_W-1];
                    x_valid_d   = 1'b1;
                end
            end

            StShift: begin
                if (bit_idx_q != '0) begin
                    bit_idx_d = idx_dec;
                    x_out_d   = pat_q[idx_dec];
                    x_valid_d = 1'b1;
                end else if (pass_left_q != '0) begin
                    pass_left_d = pass_left_q - CNT_W'(1);
                    if (gap_lat_q != '0) begin
                        state_d   = StGap;
                        gap_cnt_d = gap_lat_q;
                    end else begin
                        // Back-to-back pass, no bubble.
                        bit_idx_d = IdxMax;
                        x_out_d   = pat_q[PAT_W-1];
                        x_valid_d = 1'b1;
                    end
                end else begin
                    state_d = StDone;
                end
            end

            StGap: begin
                // gap_cnt_q counts down from the latched gap; leave when it reaches 1.
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = StShift;
                    gap_cnt_d = '0;
                    bit_idx_d = IdxMax;
                    x_out_d   = pat_q[PAT_W-1];
                    x_valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs decode straight from the state register (Moore).
    assign ready_o   = (state_q == StIdle);
    assign busy_o    = (state_q == StShift) || (state_q == StGap);
    assign done_o    = (state_q == StDone);
    assign cst_o     = state_q;
    assign x_out_o   = x_out_q;
    assign x_valid_o = x_valid_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             ready_o, x_out_o, x_valid_o, busy_o, done_o;
    logic [2:0]       cst_o;

    seq_pattern_tx #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .pattern_i(pattern),
        .reps_i   (reps),
        .gap_i    (gap),
        .ready_o  (ready_o),
        .x_out_o  (x_out_o),
        .x_valid_o(x_valid_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .cst_o    (cst_o)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EvBit, EvGap, EvDone} ev_kind_e;
    typedef struct packed {
        ev_kind_e kind;
        logic     val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic push_ev(input ev_kind_e k, input logic v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Expected output stream of a whole transfer.
    task automatic push_xfer(input logic [PAT_W-1:0] pat, input int r, input int g);
        int eff;
        eff = (r == 0) ? 1 : r;
        for (int p = 0; p < eff; p++) begin
            for (int b = PAT_W - 1; b >= 0; b--) push_ev(EvBit, pat[b]);
            if (p < eff - 1) for (int k = 0; k < g; k++) push_ev(EvGap, 1'b0);
        end
        push_ev(EvDone, 1'b0);
    endtask

    // Monitor: every active cycle must match the next scoreboard entry.
    ev_t        mon_e;
    logic [4:0] mon_want;
    always @(negedge clk) begin
        if (busy_o === 1'b1 || done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_activity", {27'd0, ready_o, busy_o, done_o, x_valid_o, x_out_o},
                      32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                // {ready, busy, done, x_valid, x_out}
                case (mon_e.kind)
                    EvBit:   mon_want = {1'b0, 1'b1, 1'b0, 1'b1, mon_e.val};
                    EvGap:   mon_want = 5'b01000;
                    default: mon_want = 5'b00100;
                endcase
                check("scoreboard", {27'd0, ready_o, busy_o, done_o, x_valid_o, x_out_o},
                      {27'd0, mon_want});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check(name, {24'd0, cst_o, ready_o, busy_o, done_o, x_valid_o, x_out_o},
              {24'd0, 3'b000, 5'b10000});
    endtask

    task automatic wait_done(input string name, input int start_cyc, input int exp_cyc);
        int cyc;
        cyc = start_cyc;
        while (done_o !== 1'b1 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check({name, "_done_cycle"}, cyc, exp_cyc);
        tick();
        check({name, "_ready_after_done"}, {31'd0, ready_o}, 32'd1);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic run_xfer(input string name, input logic [PAT_W-1:0] pat, input int r,
                            input int g, input int exp_cyc);
        pattern = pat;
        reps    = CNT_W'(r);
        gap     = GAP_W'(g);
        start   = 1'b1;
        push_xfer(pat, r, g);
        tick();
        start = 1'b0;
        check({name, "_first_bit"}, {30'd0, x_valid_o, x_out_o}, {30'd0, 1'b1, pat[PAT_W-1]});
        wait_done(name, 1, exp_cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start held high: start must be ignored.
        rst     = 1'b1;
        start   = 1'b1;
        pattern = 4'b1111;
        reps    = 4'd1;
        gap     = 4'd0;
        tick();
        tick();
        check_idle("reset_state");
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check_idle("idle_after_reset");

        run_xfer("single_1010", 4'b1010, 1, 0, 5);
        run_xfer("reps3_1010", 4'b1010, 3, 0, 13);
        run_xfer("gap2_1100", 4'b1100, 2, 2, 11);
        run_xfer("reps0_0110", 4'b0110, 0, 3, 5);

        // Start pulsed mid-transfer with other inputs: ignored.
        pattern = 4'b1010;
        reps    = 4'd2;
        gap     = 4'd1;
        start   = 1'b1;
        push_xfer(4'b1010, 2, 1);
        tick();
        start = 1'b0;
        tick();
        pattern = 4'b0101;
        reps    = 4'd3;
        gap     = 4'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore_restart", 3, 10);

        // Reset abort in cycle 3 of a reps=2 transfer.
        pattern = 4'b1011;
        reps    = 4'd2;
        gap     = 4'd0;
        start   = 1'b1;
        push_ev(EvBit, 1'b1);
        push_ev(EvBit, 1'b0);
        push_ev(EvBit, 1'b1);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort_idle");
        for (int i = 0; i < 20; i++) tick();
        check("abort_queue_drained", exp_q.size(), 0);
        run_xfer("after_abort_0011", 4'b0011, 1, 0, 5);

        // Counter boundaries: 15 passes with 15-cycle gaps -> 60 + 210 busy cycles.
        run_xfer("max_reps_gap", 4'b1001, 15, 15, 271);

        // start held high: second transfer begins the edge after DONE returns to IDLE.
        pattern = 4'b1110;
        reps    = 4'd1;
        gap     = 4'd0;
        start   = 1'b1;
        push_xfer(4'b1110, 1, 0);
        push_xfer(4'b1110, 1, 0);
        tick();
        for (int i = 0; i < 5; i++) tick();
        check("held_start_ready_c6", {31'd0, ready_o}, 32'd1);
        tick();
        start = 1'b0;
        check("held_start_restart_c7", {30'd0, x_valid_o, x_out_o}, {30'd0, 2'b11});
        wait_done("held_start", 1, 5);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits (2..16).
REQ-002 Parameter CNT_W, default 4, width of the repeat-count input.
REQ-003 Parameter GAP_W, default 4, width of the inter-pattern gap input.
REQ-004 clk  input  1  clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request to transmit; sampled only while ready=1.
REQ-007 pattern  input  PAT_W  bit pattern, sent MSB first.
REQ-008 reps  input  CNT_W  number of pattern passes; 0 SHALL be treated as 1.
REQ-009 gap  input  GAP_W  idle cycles inserted between consecutive passes.
REQ-010 ready  output  1  high only in IDLE; block can accept start.
REQ-011 x_out  output  1  serial data bit, registered.
REQ-012 x_valid  output  1  high when x_out carries a pattern bit, registered.
REQ-013 busy  output  1  high in SHIFT and GAP.
REQ-014 done  output  1  single-cycle pulse after the last bit of the last pass.
REQ-015 cst  output  3  current state code, for debug.

Function
REQ-016 The FSM SHALL be a Moore machine with states IDLE=000, SHIFT=001, GAP=010, DONE=011; other codes SHALL go to IDLE on the next edge.
REQ-017 In IDLE with start=1 at edge N, the block SHALL latch pattern, reps and gap into internal registers and enter SHIFT.
REQ-018 The first bit, pattern[PAT_W-1], SHALL appear on x_out with x_valid=1 in the cycle after edge N (latency 1).
REQ-019 In SHIFT, each edge SHALL present the next lower bit; a pass SHALL take exactly PAT_W consecutive valid cycles.
REQ-020 At the end of a pass with passes remaining and latched gap>0, the FSM SHALL enter GAP for exactly gap cycles with x_valid=0 and x_out=0.
REQ-021 At the end of a pass with passes remaining and gap=0, the next pass SHALL start on the next cycle with no bubble.
REQ-022 After the last bit of the last pass, the FSM SHALL enter DONE for one cycle with done=1, x_valid=0 and ready=0, then return to IDLE.
REQ-023 A transfer SHALL occupy reps*PAT_W valid cycles plus (reps-1)*gap idle cycles, using the effective reps after the 0-to-1 rule.
REQ-024 start, pattern, reps and gap SHALL be ignored outside IDLE; latched values SHALL NOT change mid-transfer.
REQ-025 start held high continuously SHALL start a new transfer on the edge after DONE returns to IDLE, since ready is high that cycle.
REQ-026 In IDLE, x_out, x_valid, busy and done SHALL be 0.
REQ-027 The pass counter and gap counter SHALL NOT wrap: maximum reps (2^CNT_W-1) and maximum gap (2^GAP_W-1) SHALL be sent exactly.

Reset
REQ-028 With rst=1 at an edge: cst=IDLE, x_out=0, x_valid=0, busy=0, done=0, ready=1, and internal counters and latches cleared.
REQ-029 rst SHALL take priority over start and over any in-progress transfer, including in DONE; no done pulse SHALL follow a reset abort.
REQ-030 start asserted during the reset cycle SHALL be ignored; start SHALL be accepted no earlier than the first edge with rst=0.

Verification
REQ-031 pattern=1010, reps=1, gap=0, one-cycle start -> x_out 1,0,1,0 with x_valid=1 in cycles 1-4; done=1 in cycle 5; ready=1 in cycle 6.
REQ-032 pattern=1010, reps=3, gap=0 -> 12 contiguous valid bits 101010101010; done in cycle 13.
REQ-033 pattern=1100, reps=2, gap=2 -> valid 1,1,0,0; two cycles with x_valid=0; valid 1,1,0,0; done in cycle 11.
REQ-034 reps=0, pattern=0110 -> behaves as reps=1: valid 0,1,1,0, then done.
REQ-035 start pulsed again in cycle 2 of a transfer, with different pattern and reps values -> ignored; the original transfer completes unchanged.
REQ-036 rst asserted in cycle 3 of a reps=2 transfer -> next cycle IDLE with all outputs 0 and ready=1; no done pulse; a new start is then accepted normally.
